// File: rtl/scan_chain_slave.sv
// Two-phase scan-chain slave: synchronizes the external scan clocks, shifts a
// configuration chain in, shifts a captured result word out, and flags protocol errors.
module scan_chain_slave #(
    parameter int IN_LEN  = 188,
    parameter int OUT_LEN = 50
) (
    input  logic               clk_signal_ext,
    input  logic               rst,
    input  logic               phi,
    input  logic               phib,
    input  logic               scan_i0o1,
    input  logic               load,
    input  logic               scan_in,
    input  logic [OUT_LEN-1:0] capture_data,
    output logic [IN_LEN-1:0]  cfg_q,
    output logic               cfg_valid,
    output logic               scan_out,
    output logic [7:0]         shift_cnt,
    output logic               err,
    output logic               phi_out,
    output logic               phib_out,
    output logic               scan_i0o1_out,
    output logic               load_out
);

    localparam int SI = 0;
    localparam int PH = 1;
    localparam int PB = 2;
    localparam int MD = 3;
    localparam int LD = 4;

    logic [4:0] async_in;
    logic [4:0] s1_q, s2_q, s3_q;
    logic [2:0] vld_q;

    assign async_in = {load, scan_i0o1, phib, phi, scan_in};

    // vld_q marks when the edge flop holds a real post-reset sample, so a level
    // already high at reset release never looks like a rising edge.
    always_ff @(posedge clk_signal_ext or posedge rst) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            vld_q <= '0;
        end else begin
            s1_q  <= async_in;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            vld_q <= {vld_q[1:0], 1'b1};
        end
    end

    logic phi_rise, phib_rise, load_rise, mode, din;

    assign phi_rise  = vld_q[2] & s2_q[PH] & ~s3_q[PH];
    assign phib_rise = vld_q[2] & s2_q[PB] & ~s3_q[PB];
    assign load_rise = vld_q[2] & s2_q[LD] & ~s3_q[LD];
    assign mode      = s3_q[MD];
    assign din       = s3_q[SI];

    logic [IN_LEN-1:0]  in_q, in_d, cfg_word_q, cfg_word_d;
    logic [OUT_LEN-1:0] out_q, out_d;
    logic               m_q, m_d;
    logic               cfg_valid_q, cfg_valid_d;
    logic               scan_out_q, scan_out_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               err_q, err_d;

    always_comb begin
        in_d        = in_q;
        out_d       = out_q;
        m_d         = m_q;
        cfg_word_d  = cfg_word_q;
        cfg_valid_d = 1'b0;
        scan_out_d  = out_q[OUT_LEN-1];
        cnt_d       = cnt_q;
        err_d       = err_q;

        if (phi_rise && phib_rise) begin
            err_d = 1'b1;
        end else begin
            if (phi_rise && !mode) begin
                m_d = din;
            end
            if (phib_rise) begin
                if (!mode) begin
                    in_d  = {in_q[IN_LEN-2:0], m_q};
                    out_d = {out_q[OUT_LEN-2:0], 1'b0};
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    out_d = capture_data;
                end
            end
        end

        // A load while either scan clock is high is rejected outright.
        if (load_rise) begin
            if (s2_q[PH] || s2_q[PB]) begin
                err_d = 1'b1;
            end else begin
                cfg_word_d  = in_q;
                cfg_valid_d = 1'b1;
                cnt_d       = 8'd0;
                if ({24'd0, cnt_q} != 32'(IN_LEN)) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_signal_ext or posedge rst) begin
        if (rst) begin
            in_q        <= '0;
            out_q       <= '0;
            m_q         <= 1'b0;
            cfg_word_q  <= '0;
            cfg_valid_q <= 1'b0;
            scan_out_q  <= 1'b0;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            in_q        <= in_d;
            out_q       <= out_d;
            m_q         <= m_d;
            cfg_word_q  <= cfg_word_d;
            cfg_valid_q <= cfg_valid_d;
            scan_out_q  <= scan_out_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign cfg_q         = cfg_word_q;
    assign cfg_valid     = cfg_valid_q;
    assign scan_out      = scan_out_q;
    assign shift_cnt     = cnt_q;
    assign err           = err_q;
    assign phi_out       = s2_q[PH];
    assign phib_out      = s2_q[PB];
    assign scan_i0o1_out = s2_q[MD];
    assign load_out      = s2_q[LD];

endmodule

// File: tb/tb_scan_chain_slave.sv
// Randomized bench for scan_chain_slave: a cycle-level behavioural model checked
// every cycle, plus frame-level expectations built from the bits each task shifted.
module tb_scan_chain_slave;

    localparam int IN_LEN  = 188;
    localparam int OUT_LEN = 50;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               phi = 1'b0, phib = 1'b0, mode = 1'b0, load = 1'b0, sin = 1'b0;
    logic [OUT_LEN-1:0] cd = '0;
    logic [IN_LEN-1:0]  cfg_q;
    logic               cfg_valid, scan_out, err, phi_out, phib_out, scan_i0o1_out, load_out;
    logic [7:0]         shift_cnt;

    scan_chain_slave #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN)) dut (
        .clk_signal_ext(clk), .rst(rst), .phi(phi), .phib(phib), .scan_i0o1(mode),
        .load(load), .scan_in(sin), .capture_data(cd), .cfg_q(cfg_q),
        .cfg_valid(cfg_valid), .scan_out(scan_out), .shift_cnt(shift_cnt), .err(err),
        .phi_out(phi_out), .phib_out(phib_out), .scan_i0o1_out(scan_i0o1_out),
        .load_out(load_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    endtask

    // Behavioural model: inputs seen through a sample-history delay line.
    logic [IN_LEN-1:0]  e_in, e_cfg;
    logic [OUT_LEN-1:0] e_out;
    logic               e_m, e_valid, e_so, e_err;
    int                 e_cnt;
    logic [4:0]         h0, h1, h2;
    int                 nsamp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_in = '0; e_cfg = '0; e_out = '0; e_m = 0; e_valid = 0; e_so = 0;
            e_err = 0; e_cnt = 0; h0 = '0; h1 = '0; h2 = '0; nsamp = 0;
        end else begin
            logic pr, br, lr, md, dv;
            logic [IN_LEN-1:0] old_in;
            pr = (nsamp >= 3) && h1[1] && !h2[1];
            br = (nsamp >= 3) && h1[2] && !h2[2];
            lr = (nsamp >= 3) && h1[4] && !h2[4];
            md = h2[3];
            dv = h2[0];
            old_in  = e_in;
            e_so    = e_out[OUT_LEN-1];
            e_valid = 0;
            if (pr && br) e_err = 1;
            else begin
                if (pr && !md) e_m = dv;
                if (br && !md) begin
                    e_in  = (e_in << 1) | IN_LEN'(e_m);
                    e_out = e_out << 1;
                    e_cnt = (e_cnt < 255) ? e_cnt + 1 : 255;
                end else if (br) begin
                    e_out = cd;
                end
            end
            if (lr) begin
                if (h1[1] || h1[2]) e_err = 1;
                else begin
                    if (e_cnt != IN_LEN) e_err = 1;
                    e_cfg = old_in; e_valid = 1; e_cnt = 0;
                end
            end
            h2 = h1; h1 = h0; h0 = {load, mode, phib, phi, sin};
            if (nsamp < 3) nsamp++;
        end
    end

    int vcount = 0;
    initial forever begin
        @(posedge clk); #1;
        if (cfg_valid) vcount++;
        chk("cyc_cfg_q", 256'(cfg_q), 256'(e_cfg));
        chk("cyc_cfg_valid", 256'(cfg_valid), 256'(e_valid));
        chk("cyc_scan_out", 256'(scan_out), 256'(e_so));
        chk("cyc_shift_cnt", 256'(shift_cnt), 256'(e_cnt));
        chk("cyc_err", 256'(err), 256'(e_err));
        chk("cyc_sync_outs", 256'({phi_out, phib_out, scan_i0o1_out, load_out}),
            256'({h1[1], h1[2], h1[3], h1[4]}));
    end

    // Frame-level expectations
    logic bits[$];
    int   exp_cnt = 0;

    function automatic logic [IN_LEN-1:0] exp_cfg();
        logic [IN_LEN-1:0] v = '0;
        for (int k = 0; k < IN_LEN; k++)
            if (k < bits.size()) v[k] = bits[bits.size()-1-k];
        return v;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold();
        wait_clk(int'($urandom_range(4, 5)));
    endtask

    task automatic shift_bit(input logic b);
        sin = b; hold();
        phi = 1; hold(); phi = 0; hold();
        phib = 1; hold(); phib = 0; hold();
        bits.push_back(b);
        if (exp_cnt < 255) exp_cnt++;
    endtask

    task automatic shift_rand(input int n);
        for (int i = 0; i < n; i++) shift_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic do_load(input string nm, input logic exp_err);
        vcount = 0;
        load = 1; hold(); load = 0; hold();
        exp_cnt = 0;
        chk({nm, "_cfg_q"}, 256'(cfg_q), 256'(exp_cfg()));
        chk({nm, "_valid_pulses"}, 256'(vcount), 256'(1));
        chk({nm, "_shift_cnt"}, 256'(shift_cnt), 256'(0));
        chk({nm, "_err"}, 256'(err), 256'(exp_err));
        $display("load %s: cfg_q=%0h err=%0b", nm, cfg_q, err);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_outs_zero"}, 256'({cfg_q, cfg_valid, scan_out, shift_cnt, err,
            phi_out, phib_out, scan_i0o1_out, load_out}), 256'(0));
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1; #1;
        check_zero("reset");
        bits.delete(); exp_cnt = 0;
        wait_clk(2);
        phi = 0; phib = 0; load = 0;
        wait_clk(2);
        rst = 0; wait_clk(6);
    endtask

    initial begin
        logic [7:0]         a5;
        logic [IN_LEN-1:0]  pat;
        logic [OUT_LEN-1:0] cdv;
        a5  = 8'hA5;
        pat = '0;
        // Reset with phib already high: its level must not count as an edge.
        phib = 1;
        wait_clk(3); #1;
        check_zero("initial_reset");
        @(negedge clk); rst = 0;
        wait_clk(8);
        chk("no_edge_after_reset_cnt", 256'(shift_cnt), 256'(0));
        chk("phib_out_level", 256'(phib_out), 256'(1));
        phib = 0; hold();

        // 0xA5 frame
        for (int i = 0; i < IN_LEN; i++) begin
            pat[IN_LEN-1-i] = a5[7-(i%8)];
            shift_bit(a5[7-(i%8)]);
        end
        chk("a5_cnt_before_load", 256'(shift_cnt), 256'(IN_LEN));
        do_load("a5_frame", 1'b0);
        chk("a5_cfg_literal", 256'(cfg_q), 256'(pat));
        chk("a5_model_literal", 256'(e_cfg), 256'(pat));

        // Capture then shift out
        cdv = 50'h2_AAAA_5555_1234;
        cd = cdv; mode = 1; hold();
        phib = 1; hold(); phib = 0; hold();
        mode = 0; hold();
        chk("capture_keeps_cnt", 256'(shift_cnt), 256'(0));
        for (int i = 0; i < OUT_LEN + 2; i++) begin
            chk($sformatf("scan_out_bit%0d", i), 256'(scan_out),
                256'((i < OUT_LEN) ? cdv[OUT_LEN-1-i] : 1'b0));
            shift_bit(1'($urandom_range(0, 1)));
        end
        $display("scan-out of %0h done", cdv);

        // Reset mid-shift after 100 shifts
        do_reset();
        shift_rand(100);
        chk("cnt_100", 256'(shift_cnt), 256'(100));
        phi = 1; wait_clk(2);
        rst = 1; #1;
        check_zero("midshift_reset");
        bits.delete(); exp_cnt = 0;
        wait_clk(2); phi = 0; wait_clk(2);
        @(negedge clk); rst = 0; wait_clk(6);
        shift_rand(IN_LEN);
        do_load("after_reset_frame", 1'b0);

        // Short frame sets err, a following good frame keeps it
        shift_rand(IN_LEN - 1);
        do_load("short_frame", 1'b1);
        shift_rand(IN_LEN);
        do_load("good_after_err", 1'b1);

        // Simultaneous phi/phib edges
        shift_rand(3);
        phi = 1; phib = 1; hold(); phi = 0; phib = 0; hold();
        chk("overlap_cnt", 256'(shift_cnt), 256'(exp_cnt));
        chk("overlap_err", 256'(err), 256'(1));

        // Saturation
        do_reset();
        chk("reset_clears_err", 256'(err), 256'(0));
        shift_rand(300);
        chk("cnt_saturated", 256'(shift_cnt), 256'(255));
        do_load("after_300", 1'b1);

        // Load while phi is high is rejected
        phi = 1; hold(); vcount = 0;
        load = 1; hold(); load = 0; hold(); phi = 0; hold();
        chk("load_during_phi_valid", 256'(vcount), 256'(0));
        chk("load_during_phi_cfg", 256'(cfg_q), 256'(exp_cfg()));

        // Random protocol soup, checked only by the cycle model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) phi  = ~phi;
            if ($urandom_range(0, 7) == 0) phib = ~phib;
            if ($urandom_range(0, 11) == 0) load = ~load;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 3) == 0) sin  = ~sin;
            cd = OUT_LEN'({$urandom(), $urandom()});
        end
        wait_clk(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
